mux_pipe_n: RTL and testbench



---
 rtl/mux_pipe_n_if.sv | 34 +++
 rtl/mux_pipe_n.sv | 140 ++++++++++++++
 tb/tb_mux_pipe_n.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_pipe_n_if.sv
// mux_pipe_n_if: handshake bundle for the registered N:1 select mux.
//   in_data  [N*WIDTH] packed inputs, word i at [i*WIDTH +: WIDTH]
//   sel      [SELW]    index of the word to pass, sampled with in_data
//   in_valid/in_ready  upstream handshake
//   out_data/out_sel   buffer head word and the sel that produced it
//   out_valid/out_ready downstream handshake
//   sel_err            sticky out-of-range select flag, clr_err clears it
// master = upstream/downstream environment, slave = the mux block.
interface mux_pipe_n_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
);
  logic [N*WIDTH-1:0] in_data;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;
  logic               clr_err;

  modport master (
    output in_data, sel, in_valid, out_ready, clr_err,
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, out_ready, clr_err,
    output in_ready, out_data, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: registered N:1 datapath mux feeding a 2-entry skid buffer.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_pipe_n_if.slave: in_data/sel/in_valid -> in_ready,
//          out_data/out_sel/out_valid <- out_ready, sel_err/clr_err
// All outputs come straight from flops; in_ready depends only on state.
module mux_pipe_n #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_pipe_n_if.slave  bus
);

  // Buffer occupancy doubles as the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_data_q, head_data_d;
  logic [SELW-1:0]  head_sel_q,  head_sel_d;
  logic [WIDTH-1:0] tail_data_q, tail_data_d;
  logic [SELW-1:0]  tail_sel_q,  tail_sel_d;
  logic             in_ready_q,  in_ready_d;
  logic             sel_err_q,   sel_err_d;

  logic [WIDTH-1:0] pick_data_c;
  logic             sel_oor_c;
  logic             push_c;
  logic             pop_c;

  // Input word selection; an out-of-range sel matches nothing and yields zero.
  always_comb begin : sel_mux
    pick_data_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.sel == SELW'(i)) begin
        pick_data_c = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sel_oor_c = (32'(bus.sel) >= N);

  // Handshakes; in_ready_q is already low when FULL, so no push can occur then.
  assign push_c = bus.in_valid && in_ready_q;
  assign pop_c  = (state_q != EMPTY) && bus.out_ready;

  // Next-state: occupancy, entry moves, ready and sticky error.
  always_comb begin : next_state
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    tail_data_d = tail_data_q;
    tail_sel_d  = tail_sel_q;
    sel_err_d   = sel_err_q;

    unique case (state_q)
      EMPTY: begin
        if (push_c) begin
          state_d     = ONE;
          head_data_d = pick_data_c;
          head_sel_d  = bus.sel;
        end
      end
      ONE: begin
        unique case ({push_c, pop_c})
          2'b10: begin
            state_d     = FULL;
            tail_data_d = pick_data_c;
            tail_sel_d  = bus.sel;
          end
          2'b01: begin
            // Head keeps its last value; out_valid drops.
            state_d = EMPTY;
          end
          2'b11: begin
            // Head leaves while the new beat takes its place.
            head_data_d = pick_data_c;
            head_sel_d  = bus.sel;
          end
          default: begin
          end
        endcase
      end
      FULL: begin
        if (pop_c) begin
          state_d     = ONE;
          head_data_d = tail_data_q;
          head_sel_d  = tail_sel_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Ready is registered from the next occupancy to keep stall paths cut.
    in_ready_d = (state_d != FULL);

    // Set beats clear when both land on the same edge.
    if (push_c && sel_oor_c) begin
      sel_err_d = 1'b1;
    end else if (bus.clr_err) begin
      sel_err_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_data_q <= '0;
      head_sel_q  <= '0;
      tail_data_q <= '0;
      tail_sel_q  <= '0;
      in_ready_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      tail_data_q <= tail_data_d;
      tail_sel_q  <= tail_sel_d;
      in_ready_q  <= in_ready_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = head_data_q;
  assign bus.out_sel   = head_sel_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_pipe_n.sv
// tb_mux_pipe_n: directed checks of mux_pipe_n in four parameterisations
// (32x4, 8x3 with out-of-range selects, 1x2 and 64x16) plus a scoreboard
// run with random valid/ready on the 32x4 instance.
module tb_mux_pipe_n;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_pipe_n_if #(.WIDTH(32), .N(4),  .SELW(2)) b4 ();
  mux_pipe_n_if #(.WIDTH(8),  .N(3),  .SELW(2)) b3 ();
  mux_pipe_n_if #(.WIDTH(1),  .N(2),  .SELW(1)) ba ();
  mux_pipe_n_if #(.WIDTH(64), .N(16), .SELW(4)) bb ();

  mux_pipe_n #(.WIDTH(32), .N(4),  .SELW(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_pipe_n #(.WIDTH(8),  .N(3),  .SELW(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  mux_pipe_n #(.WIDTH(1),  .N(2),  .SELW(1)) ua (.clk(clk), .rst_n(rst_n), .bus(ba));
  mux_pipe_n #(.WIDTH(64), .N(16), .SELW(4)) ub (.clk(clk), .rst_n(rst_n), .bus(bb));

  int checks = 0;
  int passes = 0;

  logic [31:0] exp4 [4] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'hDDDD_DDDD};
  logic [33:0] sbq [$];
  logic [33:0] fr;
  logic [63:0] expb;
  bit          pu, po;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock and settle just past the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b4.in_data = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    b4.sel = '0; b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.clr_err = 1'b0;
    b3.in_data = {8'h33, 8'h22, 8'h11};
    b3.sel = '0; b3.in_valid = 1'b0; b3.out_ready = 1'b1; b3.clr_err = 1'b0;
    ba.in_data = 2'b10;
    ba.sel = '0; ba.in_valid = 1'b0; ba.out_ready = 1'b0; ba.clr_err = 1'b0;
    bb.in_data = '0;
    for (int i = 0; i < 16; i++) bb.in_data[i*64 +: 64] = {16{4'(i)}};
    bb.sel = '0; bb.in_valid = 1'b0; bb.out_ready = 1'b0; bb.clr_err = 1'b0;

    // Reset state and release
    #12;
    chk("rst_in_ready",  b4.in_ready,  0);
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_sel_err",   b4.sel_err,   0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready",  b4.in_ready,  1);
    chk("rel_out_valid", b4.out_valid, 0);

    // Select sweep, back-to-back with out_ready high
    b4.out_ready = 1'b1;
    b4.in_valid  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      b4.sel = 2'(s);
      tick();
      chk("sweep_valid", b4.out_valid, 1);
      chk("sweep_data",  b4.out_data,  exp4[s]);
      chk("sweep_sel",   b4.out_sel,   64'(s));
      chk("sweep_ready", b4.in_ready,  1);
    end
    b4.in_valid = 1'b0;
    tick();
    chk("sweep_drain", b4.out_valid, 0);

    // Backpressure: three beats offered with out_ready low
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.sel = 2'd1;
    tick();
    chk("bp1_data",  b4.out_data, 32'hBBBB_BBBB);
    chk("bp1_ready", b4.in_ready, 1);
    b4.sel = 2'd2;
    tick();
    chk("bp2_ready", b4.in_ready, 0);
    chk("bp2_data",  b4.out_data, 32'hBBBB_BBBB);
    b4.sel = 2'd3;
    tick();
    chk("bp3_ready", b4.in_ready, 0);
    chk("bp3_data",  b4.out_data, 32'hBBBB_BBBB);
    chk("bp3_sel",   b4.out_sel,  1);
    chk("bp3_valid", b4.out_valid, 1);
    b4.out_ready = 1'b1;
    tick();
    chk("bp_pop1_data",  b4.out_data, 32'hCCCC_CCCC);
    chk("bp_pop1_ready", b4.in_ready, 1);
    tick();
    chk("bp_pop2_data", b4.out_data, 32'hDDDD_DDDD);
    chk("bp_pop2_sel",  b4.out_sel,  3);
    b4.in_valid = 1'b0;
    tick();
    chk("bp_empty", b4.out_valid, 0);

    // Random valid/ready on both sides against a queue model
    for (int c = 0; c < 10003; c++) begin
      b4.in_valid  = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      b4.out_ready = (c < 10000) ? 1'($urandom_range(0, 1)) : 1'b1;
      b4.sel       = 2'($urandom_range(0, 3));
      b4.in_data   = {$urandom, $urandom, $urandom, $urandom};
      chk("sb_valid", b4.out_valid, 64'(sbq.size() != 0));
      chk("sb_ready", b4.in_ready,  64'(sbq.size() != 2));
      po = (sbq.size() != 0) && b4.out_ready;
      pu = b4.in_valid && (sbq.size() != 2);
      if (po) begin
        fr = sbq.pop_front();
        chk("sb_data", b4.out_data, 64'(fr[31:0]));
        chk("sb_sel",  b4.out_sel,  64'(fr[33:32]));
      end
      if (pu) sbq.push_back({b4.sel, b4.in_data[int'(b4.sel)*32 +: 32]});
      tick();
    end
    chk("sb_final_empty", b4.out_valid, 0);

    // Reset mid-burst with both entries full
    b4.in_data   = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    b4.out_ready = 1'b0;
    b4.in_valid  = 1'b1;
    b4.sel       = 2'd1;
    tick();
    tick();
    chk("mid_full_ready", b4.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b4.out_valid, 0);
    chk("mid_rst_ready", b4.in_ready,  0);
    chk("mid_rst_data",  b4.out_data,  0);
    chk("mid_rst_sel",   b4.out_sel,   0);
    chk("mid_rst_err",   b4.sel_err,   0);
    b4.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", b4.in_ready,  1);
    chk("mid_rel_valid", b4.out_valid, 0);

    // Out-of-range selects on the 3-input instance
    b3.sel = 2'd3; b3.in_valid = 1'b1;
    tick();
    chk("oor_valid", b3.out_valid, 1);
    chk("oor_data",  b3.out_data,  0);
    chk("oor_sel",   b3.out_sel,   3);
    chk("oor_err",   b3.sel_err,   1);
    b3.in_valid = 1'b0;
    tick();
    chk("oor_err_hold", b3.sel_err, 1);
    b3.clr_err = 1'b1;
    tick();
    chk("oor_clr", b3.sel_err, 0);
    tick();
    chk("oor_clr_idle", b3.sel_err, 0);
    b3.clr_err = 1'b0; b3.sel = 2'd2; b3.in_valid = 1'b1;
    tick();
    chk("inr_data", b3.out_data, 8'h33);
    chk("inr_sel",  b3.out_sel,  2);
    chk("inr_err",  b3.sel_err,  0);
    b3.sel = 2'd3;
    tick();
    chk("oor2_err",  b3.sel_err,  1);
    chk("oor2_data", b3.out_data, 0);
    b3.clr_err = 1'b1;
    tick();
    chk("oor_set_wins", b3.sel_err, 1);
    b3.in_valid = 1'b0;
    tick();
    chk("oor_final_clr", b3.sel_err, 0);
    b3.clr_err = 1'b0;

    // WIDTH=1, N=2: sweep then backpressure
    ba.out_ready = 1'b1; ba.in_valid = 1'b1; ba.sel = 1'b0;
    tick();
    chk("a_sw0_data", ba.out_data, 0);
    chk("a_sw0_sel",  ba.out_sel,  0);
    ba.sel = 1'b1;
    tick();
    chk("a_sw1_data", ba.out_data, 1);
    chk("a_sw1_sel",  ba.out_sel,  1);
    ba.in_valid = 1'b0;
    tick();
    chk("a_sw_empty", ba.out_valid, 0);
    ba.out_ready = 1'b0; ba.in_valid = 1'b1; ba.sel = 1'b1;
    tick();
    chk("a_bp1_ready", ba.in_ready, 1);
    ba.sel = 1'b0;
    tick();
    chk("a_bp2_ready", ba.in_ready, 0);
    chk("a_bp2_data",  ba.out_data, 1);
    ba.sel = 1'b1;
    tick();
    chk("a_bp3_ready", ba.in_ready, 0);
    chk("a_bp3_data",  ba.out_data, 1);
    ba.out_ready = 1'b1;
    tick();
    chk("a_pop1_data", ba.out_data, 0);
    chk("a_pop1_sel",  ba.out_sel,  0);
    tick();
    chk("a_pop2_data", ba.out_data, 1);
    ba.in_valid = 1'b0;
    tick();
    chk("a_empty", ba.out_valid, 0);

    // WIDTH=64, N=16: sweep then backpressure
    bb.out_ready = 1'b1; bb.in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      bb.sel = 4'(s);
      tick();
      expb = 64'h1111_1111_1111_1111 * 64'(s);
      chk("b_sweep_data",  bb.out_data,  expb);
      chk("b_sweep_sel",   bb.out_sel,   64'(s));
      chk("b_sweep_valid", bb.out_valid, 1);
    end
    bb.in_valid = 1'b0;
    tick();
    chk("b_sweep_empty", bb.out_valid, 0);
    bb.out_ready = 1'b0; bb.in_valid = 1'b1; bb.sel = 4'd15;
    tick();
    bb.sel = 4'd0;
    tick();
    chk("b_bp2_ready", bb.in_ready, 0);
    bb.sel = 4'd7;
    tick();
    chk("b_bp3_data",  bb.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_bp3_ready", bb.in_ready, 0);
    bb.out_ready = 1'b1;
    tick();
    chk("b_pop1_data", bb.out_data, 0);
    chk("b_pop1_sel",  bb.out_sel,  0);
    tick();
    chk("b_pop2_data", bb.out_data, 64'h7777_7777_7777_7777);
    chk("b_pop2_sel",  bb.out_sel,  7);
    bb.in_valid = 1'b0;
    tick();
    chk("b_empty", bb.out_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
